pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
//  It is an elastic pipeline register with a valid/ready handshake, a 1-entry skid
//  buffer, stall and flush controls, occupancy and a saturating bubble counter.
//  It sits between any two CPU stages. DATA_W is sized to the stage bundle
//  (pc, inst, control and data fields, concatenated by the instantiating stage).
// PARAMETERS
//  DATA_W     32             width of the payload bundle
//  FLUSH_VAL  {DATA_W{1'b0}} value driven on data_o after reset/flush (NOP bundle)
//  CNT_W      16             width of the bubble counter
// PORTS
//  clk_i         in   1       clock; all state updates on its rising edge
//  rst_i         in   1       reset: asynchronous, active-low
//  start_i       in   1       CPU run enable; 0 = freeze (no accept, no emit)
//  flush_i       in   1       kill all held and incoming beats (branch/jump taken)
//  stall_i       in   1       hazard stall: hold contents, block accept and emit
//  valid_i       in   1       upstream beat valid
//  ready_o       out  1       stage can accept a beat this cycle
//  data_i        in   DATA_W  upstream payload
//  valid_o       out  1       data_o holds a valid beat
//  ready_i       in   1       downstream accepts a beat this cycle
//  data_o        out  DATA_W  payload to the next stage (registered)
//  occupancy_o   out  2       beats held: 0, 1 or 2
//  bubble_cnt_o  out  CNT_W   cycles with start_i=1 and valid_o=0; saturates
// BEHAVIOUR
//  - Storage: main register (drives data_o and valid_o) and skid register.
//  - States: EMPTY (occ 0), ONE (main valid), TWO (main and skid valid).
//  - Reset (rst_i=0, async): state EMPTY, valid_o=0, data_o=FLUSH_VAL, skid=0,
//    bubble_cnt_o=0, occupancy_o=0. ready_o=0 while in reset.
//  - ready_o = start_i & ~stall_i & (state!=TWO). Combinational in these three terms only.
//    It never depends on valid_i, ready_i or flush_i.
//  - acc = valid_i & ready_o.  emit = valid_o & ready_i & start_i & ~stall_i.
//  - valid_o = main valid. It is registered and stays high through stall_i and start_i=0.
//  - Transitions, with flush_i=0:
//    EMPTY: acc -> ONE, main<=data_i.
//    ONE:   acc&emit -> ONE, main<=data_i.  acc&~emit -> TWO, skid<=data_i.
//           emit&~acc -> EMPTY, data_o holds its last value.  Neither -> hold.
//    TWO:   emit -> ONE, main<=skid.  Otherwise hold.  acc is impossible (ready_o=0).
//  - Ordering is strict FIFO. No beat is duplicated or dropped unless flush_i is high.
//  - Latency: 1 cycle from acc to valid_o when EMPTY, or when in ONE with a same-cycle emit.
//  - Throughput: 1 beat/cycle sustained while ready_i=1.
//  - flush_i=1 takes priority over everything:
//    next state EMPTY, valid_o<=0, data_o<=FLUSH_VAL, skid cleared.
//    A beat accepted in the flush cycle is discarded (upstream sees it as taken).
//    An emit in the flush cycle still counts as delivered downstream.
//  - flush_i together with stall_i: flush wins. start_i=0 does not block flush.
//  - bubble_cnt_o: +1 per cycle with start_i=1 and valid_o=0.
//    It saturates at 2^CNT_W-1 and is cleared only by reset.
//  - occupancy_o is registered and reflects the current state encoding.
// STRUCTURE
//  - Package cpu_pipe_pkg: typedef enum logic[1:0] {PS_EMPTY, PS_ONE, PS_TWO} pipe_state_t;
//    plus the NOP bundle constant used as FLUSH_VAL by the CPU.
//  - One sub-module: pipe_sat_counter (CNT_W, inc, saturating, async active-low reset).
//  - Control FSM and datapath muxes stay inline.
// TESTING
//  1 Reset: rst_i=0 mid-transfer with occ=2 -> immediately valid_o=0, occupancy_o=0,
//    data_o=FLUSH_VAL, bubble_cnt_o=0.
//  2 Streaming: ready_i=1, inject 0x11,0x22,0x33 back-to-back -> data_o 0x11,0x22,0x33
//    on consecutive cycles starting 1 cycle after the first accept; occ stays 1.
//  3 Backpressure: ready_i=0 with 0x11 then 0x22 sent -> occ=2, ready_o=0.
//    Then ready_i=1 -> 0x11 then 0x22 out in order; ready_o returns to 1 after the first emit.
//  4 Flush: occ=2 with valid_i=1, data 0x44, flush_i=1 and stall_i=1 for one cycle
//    -> next cycle occ=0, valid_o=0, data_o=FLUSH_VAL; 0x44 is never emitted.
//  5 Stall/freeze: occ=1 holding 0x55, stall_i=1 for 3 cycles with ready_i=1
//    -> ready_o=0, valid_o=1, data_o=0x55 held, no emit; with start_i=0 same result.
//  6 Counter: CNT_W=4, start_i=1, idle 20 cycles -> bubble_cnt_o saturates at 15.
//    Idle with start_i=0 -> no increment.

Source files
------------

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared types and constants for the elastic CPU pipeline stage register.
package cpu_pipe_pkg;

    // Occupancy states of the stage; the encoding equals the number of beats held.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_t;

    // Default payload width of a stage bundle.
    localparam int unsigned PIPE_DATA_W = 32;

    // NOP bundle the CPU loads into a stage after reset or a flush (addi x0,x0,0).
    localparam logic [PIPE_DATA_W-1:0] PIPE_NOP_BUNDLE = 32'h0000_0013;

    // Number of beats held in a given state.
    function automatic logic [1:0] state_occupancy(input pipe_state_t s);
        logic [1:0] occ;
        case (s)
            PS_ONE:  occ = 2'd1;
            PS_TWO:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready handshake bundle between two pipeline stages.
// Signal names are seen from the stage register: *_i flows into it, *_o out of it.
interface pipe_stage_elastic_if
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W
);
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data_i;
    logic              valid_o;
    logic              ready_i;
    logic [DATA_W-1:0] data_o;

    // Stage register side.
    modport slave (
        input  valid_i,
        input  data_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output data_o
    );

    // Surrounding stages (upstream producer and downstream consumer).
    modport master (
        output valid_i,
        output data_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  data_o
    );
endinterface

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter: counts cycles with inc_i high, sticks at all-ones.
module pipe_sat_counter
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    // Saturation detect.
    always_comb begin
        w_at_max = (r_cnt == '1);
    end

    // Count register; cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (inc_i && !w_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;
endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: main register plus a 1-entry skid buffer,
// valid/ready handshake, stall/freeze/flush control and a saturating bubble counter.
module pipe_stage_elastic
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 flush_i,
    input  logic                 stall_i,
    pipe_stage_elastic_if.slave  bus,
    output logic [1:0]           occupancy_o,
    output logic [CNT_W-1:0]     bubble_cnt_o
);
    pipe_state_t       r_state;
    pipe_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_skid_nxt;

    logic w_valid;
    logic w_ready;
    logic w_run;
    logic w_acc;
    logic w_emit;
    logic w_bubble;

    // Handshake qualifiers. ready is also forced low while reset is asserted,
    // otherwise it depends only on start, stall and whether the skid is full.
    always_comb begin
        w_valid  = (r_state != PS_EMPTY);
        w_run    = start_i & ~stall_i;
        w_ready  = rst_i & w_run & (r_state != PS_TWO);
        w_acc    = bus.valid_i & w_ready;
        w_emit   = w_valid & bus.ready_i & w_run;
        w_bubble = start_i & ~w_valid;
    end

    // Next-state and datapath mux; flush overrides every other condition.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush_i) begin
            w_state_nxt = PS_EMPTY;
            w_main_nxt  = FLUSH_VAL;
            w_skid_nxt  = '0;
        end else begin
            case (r_state)
                PS_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt = PS_ONE;
                        w_main_nxt  = bus.data_i;
                    end
                end
                PS_ONE: begin
                    if (w_acc && w_emit) begin
                        w_main_nxt  = bus.data_i;
                    end else if (w_acc) begin
                        w_state_nxt = PS_TWO;
                        w_skid_nxt  = bus.data_i;
                    end else if (w_emit) begin
                        // data_o keeps the last delivered beat while empty.
                        w_state_nxt = PS_EMPTY;
                    end
                end
                PS_TWO: begin
                    if (w_emit) begin
                        w_state_nxt = PS_ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = PS_EMPTY;
                end
            endcase
        end
    end

    // State and storage registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= PS_EMPTY;
            r_main  <= FLUSH_VAL;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_bubble),
        .cnt_o (bubble_cnt_o)
    );

    assign bus.ready_o  = w_ready;
    assign bus.valid_o  = w_valid;
    assign bus.data_o   = r_main;
    assign occupancy_o  = state_occupancy(r_state);
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed scenarios with inline
// checks plus a FIFO scoreboard tracking every accepted and emitted beat.
module tb_pipe_stage_elastic;
    import cpu_pipe_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam logic [DW-1:0] NOP = PIPE_NOP_BUNDLE;

    logic          clk_i;
    logic          rst_i;
    logic          start_i;
    logic          flush_i;
    logic          stall_i;
    logic [1:0]    occupancy_o;
    logic [CW-1:0] bubble_cnt_o;

    int n_checks;
    int n_pass;
    logic [DW-1:0] sb_q[$];

    pipe_stage_elastic_if #(.DATA_W(DW)) u_if ();

    pipe_stage_elastic #(
        .DATA_W    (DW),
        .FLUSH_VAL (NOP),
        .CNT_W     (CW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .flush_i      (flush_i),
        .stall_i      (stall_i),
        .bus          (u_if),
        .occupancy_o  (occupancy_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard: inputs are stable from posedge+1 to the next posedge, so the
    // falling edge sees exactly what the next rising edge will act on.
    always @(negedge clk_i) begin
        logic [DW-1:0] exp_d;
        if (rst_i) begin
            if (u_if.valid_o && u_if.ready_i && start_i && !stall_i) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL sb_emit: unexpected beat %h emitted, none expected", u_if.data_o);
                end else begin
                    exp_d = sb_q.pop_front();
                    if (u_if.data_o !== exp_d)
                        $display("FAIL sb_order: got %h expected %h", u_if.data_o, exp_d);
                    else
                        n_pass++;
                end
            end
            if (flush_i)
                sb_q.delete();
            else if (u_if.valid_i && u_if.ready_o)
                sb_q.push_back(u_if.data_i);
        end
    end

    task automatic test_reset();
        u_if.ready_i = 1'b0;
        u_if.valid_i = 1'b1; u_if.data_i = 32'hA1; tick();
        u_if.data_i  = 32'hA2; tick();
        u_if.valid_i = 1'b0;
        n_checks++;
        if (occupancy_o !== 2'd2 || u_if.ready_o !== 1'b0)
            $display("FAIL reset_fill: occ=%0d ready=%b expected occ=2 ready=0", occupancy_o, u_if.ready_o);
        else n_pass++;
        #2;
        rst_i = 1'b0;
        #1;
        n_checks++;
        if (u_if.valid_o !== 1'b0 || occupancy_o !== 2'd0)
            $display("FAIL reset_state: valid=%b occ=%0d expected 0/0", u_if.valid_o, occupancy_o);
        else n_pass++;
        n_checks++;
        if (u_if.data_o !== NOP)
            $display("FAIL reset_data: got %h expected %h", u_if.data_o, NOP);
        else n_pass++;
        n_checks++;
        if (bubble_cnt_o !== '0 || u_if.ready_o !== 1'b0)
            $display("FAIL reset_cnt_ready: cnt=%0d ready=%b expected 0/0", bubble_cnt_o, u_if.ready_o);
        else n_pass++;
        sb_q.delete();
        tick();
        rst_i = 1'b1;
        tick();
        n_checks++;
        if (occupancy_o !== 2'd0 || u_if.valid_o !== 1'b0 || u_if.ready_o !== 1'b1)
            $display("FAIL reset_release: occ=%0d valid=%b ready=%b expected 0/0/1",
                     occupancy_o, u_if.valid_o, u_if.ready_o);
        else n_pass++;
    endtask

    task automatic test_streaming();
        logic [DW-1:0] beats[3];
        beats[0] = 32'h11; beats[1] = 32'h22; beats[2] = 32'h33;
        u_if.ready_i = 1'b1;
        u_if.valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            u_if.data_i = beats[i];
            tick();
            if (i == 2) u_if.valid_i = 1'b0;
            n_checks++;
            if (u_if.valid_o !== 1'b1 || u_if.data_o !== beats[i] || occupancy_o !== 2'd1)
                $display("FAIL stream_beat%0d: valid=%b data=%h occ=%0d expected 1/%h/1",
                         i, u_if.valid_o, u_if.data_o, occupancy_o, beats[i]);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (u_if.valid_o !== 1'b0 || occupancy_o !== 2'd0 || u_if.data_o !== 32'h33)
            $display("FAIL stream_drain: valid=%b occ=%0d data=%h expected 0/0/00000033",
                     u_if.valid_o, occupancy_o, u_if.data_o);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        u_if.ready_i = 1'b0;
        u_if.valid_i = 1'b1; u_if.data_i = 32'h11; tick();
        n_checks++;
        if (occupancy_o !== 2'd1 || u_if.ready_o !== 1'b1)
            $display("FAIL bp_one: occ=%0d ready=%b expected 1/1", occupancy_o, u_if.ready_o);
        else n_pass++;
        u_if.data_i = 32'h22; tick();
        u_if.valid_i = 1'b0;
        tick();
        n_checks++;
        if (occupancy_o !== 2'd2 || u_if.ready_o !== 1'b0 || u_if.data_o !== 32'h11)
            $display("FAIL bp_two: occ=%0d ready=%b data=%h expected 2/0/00000011",
                     occupancy_o, u_if.ready_o, u_if.data_o);
        else n_pass++;
        u_if.ready_i = 1'b1;
        tick();
        n_checks++;
        if (occupancy_o !== 2'd1 || u_if.ready_o !== 1'b1 || u_if.data_o !== 32'h22)
            $display("FAIL bp_first_emit: occ=%0d ready=%b data=%h expected 1/1/00000022",
                     occupancy_o, u_if.ready_o, u_if.data_o);
        else n_pass++;
        tick();
        n_checks++;
        if (occupancy_o !== 2'd0 || u_if.valid_o !== 1'b0)
            $display("FAIL bp_drain: occ=%0d valid=%b expected 0/0", occupancy_o, u_if.valid_o);
        else n_pass++;
    endtask

    task automatic test_flush();
        u_if.ready_i = 1'b0;
        u_if.valid_i = 1'b1; u_if.data_i = 32'h66; tick();
        u_if.data_i  = 32'h77; tick();
        u_if.data_i  = 32'h44;
        flush_i = 1'b1; stall_i = 1'b1;
        tick();
        flush_i = 1'b0; stall_i = 1'b0; u_if.valid_i = 1'b0;
        n_checks++;
        if (occupancy_o !== 2'd0 || u_if.valid_o !== 1'b0 || u_if.data_o !== NOP)
            $display("FAIL flush_state: occ=%0d valid=%b data=%h expected 0/0/%h",
                     occupancy_o, u_if.valid_o, u_if.data_o, NOP);
        else n_pass++;
        u_if.ready_i = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (u_if.valid_o !== 1'b0 || occupancy_o !== 2'd0)
            $display("FAIL flush_no_emit: valid=%b occ=%0d expected 0/0", u_if.valid_o, occupancy_o);
        else n_pass++;
    endtask

    task automatic test_stall_freeze();
        u_if.ready_i = 1'b0;
        u_if.valid_i = 1'b1; u_if.data_i = 32'h55; tick();
        u_if.ready_i = 1'b1; u_if.data_i = 32'h99;
        for (int mode = 0; mode < 2; mode++) begin
            if (mode == 0) begin stall_i = 1'b1; start_i = 1'b1; end
            else           begin stall_i = 1'b0; start_i = 1'b0; end
            for (int c = 0; c < 3; c++) begin
                tick();
                n_checks++;
                if (u_if.ready_o !== 1'b0 || u_if.valid_o !== 1'b1 ||
                    u_if.data_o !== 32'h55 || occupancy_o !== 2'd1)
                    $display("FAIL hold_m%0d_c%0d: ready=%b valid=%b data=%h occ=%0d expected 0/1/00000055/1",
                             mode, c, u_if.ready_o, u_if.valid_o, u_if.data_o, occupancy_o);
                else n_pass++;
            end
        end
        start_i = 1'b1; stall_i = 1'b0; u_if.valid_i = 1'b0;
        tick();
        n_checks++;
        if (u_if.valid_o !== 1'b0 || occupancy_o !== 2'd0)
            $display("FAIL hold_release: valid=%b occ=%0d expected 0/0", u_if.valid_o, occupancy_o);
        else n_pass++;
    endtask

    task automatic test_counter();
        int unsigned exp_cnt;
        u_if.valid_i = 1'b0;
        start_i = 1'b0;
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (bubble_cnt_o !== 4'd0)
            $display("FAIL cnt_frozen_idle: got %0d expected 0", bubble_cnt_o);
        else n_pass++;
        exp_cnt = 0;
        start_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) start_i = 1'b0;
            if (c == 8) start_i = 1'b1;
            tick();
            if (start_i && exp_cnt < 15) exp_cnt++;
            if (c == 4 || c == 7 || c == 19) begin
                n_checks++;
                if (bubble_cnt_o !== exp_cnt[CW-1:0])
                    $display("FAIL cnt_c%0d: got %0d expected %0d", c, bubble_cnt_o, exp_cnt);
                else n_pass++;
            end
        end
        repeat (3) tick();
        n_checks++;
        if (bubble_cnt_o !== 4'd15)
            $display("FAIL cnt_saturate: got %0d expected 15", bubble_cnt_o);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_i    = 1'b0;
        start_i  = 1'b1;
        flush_i  = 1'b0;
        stall_i  = 1'b0;
        u_if.valid_i = 1'b0;
        u_if.ready_i = 1'b0;
        u_if.data_i  = '0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();

        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_stall_freeze();
        test_counter();

        n_checks++;
        if (sb_q.size() != 0)
            $display("FAIL sb_leftover: %0d beats never emitted, expected 0", sb_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
